coherent_avg_sequencer: RTL and testbench

//  Sequences the coherent-averaging datapath: accepts the frame count written by the CPU

---
 rtl/coherent_avg_sequencer.sv | 173 +++++++++++++++++
 tb/tb_coherent_avg_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/coherent_avg_sequencer.sv
// Coherent-averaging sequencer: arms on a frame trigger and steps the accumulator RAM
// over FRAME_LEN samples for N frames. Optional trigger-wait timeout: COH_AVG_TIMEOUT_EN.
module coherent_avg_sequencer #(
  parameter int FRAME_LEN      = 1024,
  parameter int ADDR_W         = 10,
  parameter int TIMEOUT_CYCLES = 16777216
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       n_frames,
  input  logic              start,
  input  logic              abort,
  input  logic              trigger,
  input  logic              sample_valid,
  output logic              acc_we,
  output logic              acc_first,
  output logic [ADDR_W-1:0] acc_addr,
  output logic [15:0]       frame_idx,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic              timeout
);

  if (FRAME_LEN < 2 || (2 ** ADDR_W) < FRAME_LEN || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("coherent_avg_sequencer: invalid parameter combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_ACQ, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST_SAMPLE = ADDR_W'(FRAME_LEN - 1);

  state_t              state_q, state_d;
  logic [15:0]         n_lat_q, n_lat_d;
  logic [15:0]         frame_q, frame_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                acc_we_q, acc_we_d;
  logic                acc_first_q, acc_first_d;
  logic [ADDR_W-1:0]   acc_addr_q, acc_addr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
`ifdef COH_AVG_TIMEOUT_EN
  logic [31:0]         tmo_q, tmo_d;
  logic                timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    n_lat_d     = n_lat_q;
    frame_d     = frame_q;
    cnt_d       = cnt_q;
    acc_we_d    = 1'b0;
    acc_first_d = acc_first_q;
    acc_addr_d  = acc_addr_q;
    done_d      = 1'b0;
    overrun_d   = overrun_q;
`ifdef COH_AVG_TIMEOUT_EN
    tmo_d       = tmo_q;
    timeout_d   = timeout_q;
`endif
    // Abort wins over everything; sticky flags simply keep their held value.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          // busy_q is still high during the done cycle, so a start there is ignored too.
          if (start && !busy_q) begin
            n_lat_d   = (n_frames == 16'd0) ? 16'd1 : n_frames;
            frame_d   = 16'd0;
            overrun_d = 1'b0;
            state_d   = S_ARM;
`ifdef COH_AVG_TIMEOUT_EN
            timeout_d = 1'b0;
            tmo_d     = 32'd0;
`endif
          end
        end
        S_ARM: begin
          if (trigger) begin
            state_d = S_ACQ;
            cnt_d   = '0;
          end
`ifdef COH_AVG_TIMEOUT_EN
          else if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_IDLE;
          end else begin
            tmo_d = tmo_q + 32'd1;
          end
`endif
        end
        S_ACQ: begin
          if (trigger) overrun_d = 1'b1;
          if (sample_valid) begin
            acc_we_d    = 1'b1;
            acc_addr_d  = cnt_q;
            acc_first_d = (frame_q == 16'd0);
            if (cnt_q == LAST_SAMPLE) begin
              if (frame_q == 16'(n_lat_q - 16'd1)) begin
                state_d = S_DONE;
              end else begin
                frame_d = frame_q + 16'd1;
                state_d = S_ARM;
`ifdef COH_AVG_TIMEOUT_EN
                tmo_d   = 32'd0;
`endif
              end
            end else begin
              cnt_d = cnt_q + ADDR_W'(1);
            end
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
    // busy stays high through the registered done pulse that follows S_DONE.
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE && !abort);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      n_lat_q     <= 16'd0;
      frame_q     <= 16'd0;
      cnt_q       <= '0;
      acc_we_q    <= 1'b0;
      acc_first_q <= 1'b0;
      acc_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef COH_AVG_TIMEOUT_EN
      tmo_q       <= 32'd0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      n_lat_q     <= n_lat_d;
      frame_q     <= frame_d;
      cnt_q       <= cnt_d;
      acc_we_q    <= acc_we_d;
      acc_first_q <= acc_first_d;
      acc_addr_q  <= acc_addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overrun_q   <= overrun_d;
`ifdef COH_AVG_TIMEOUT_EN
      tmo_q       <= tmo_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

  assign acc_we    = acc_we_q;
  assign acc_first = acc_first_q;
  assign acc_addr  = acc_addr_q;
  assign frame_idx = frame_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overrun   = overrun_q;
`ifdef COH_AVG_TIMEOUT_EN
  assign timeout   = timeout_q;
`else
  assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_coherent_avg_sequencer.sv
// Randomized bench for coherent_avg_sequencer: observed accumulator writes are compared
// against the ideal sequence (addr = i mod FRAME_LEN, first = i < FRAME_LEN).
module tb_coherent_avg_sequencer;
  localparam int FL  = 8;
  localparam int AW  = 3;
  localparam int TMO = 100;

  logic          clk;
  logic          reset_n;
  logic [15:0]   n_frames;
  logic          start, abort, trigger, sample_valid;
  logic          acc_we, acc_first;
  logic [AW-1:0] acc_addr;
  logic [15:0]   frame_idx;
  logic          busy, done, overrun, timeout;

  coherent_avg_sequencer #(.FRAME_LEN(FL), .ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset_n(reset_n), .n_frames(n_frames), .start(start), .abort(abort),
    .trigger(trigger), .sample_valid(sample_valid), .acc_we(acc_we), .acc_first(acc_first),
    .acc_addr(acc_addr), .frame_idx(frame_idx), .busy(busy), .done(done),
    .overrun(overrun), .timeout(timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int obs_addr[$];
  bit obs_first[$];
  int done_cnt, done_cyc, last_we_cyc, done_nobusy;

  always @(negedge clk) begin
    if (reset_n) begin
      cyc++;
      if (acc_we) begin
        obs_addr.push_back(int'(acc_addr));
        obs_first.push_back(acc_first);
        last_we_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        if (!busy) done_nobusy++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs_addr.delete();
    obs_first.delete();
    done_cnt = 0; done_cyc = -1; last_we_cyc = -1; done_nobusy = 0;
  endtask

  // Number of observed writes that differ from the ideal run sequence.
  function automatic int write_errors();
    int e = 0;
    for (int i = 0; i < obs_addr.size(); i++) begin
      if (obs_addr[i] != (i % FL) || obs_first[i] != (i < FL)) e++;
    end
    return e;
  endfunction

  task automatic do_start(input int n);
    n_frames = 16'(n);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_frames = 16'($urandom);
  endtask

  task automatic send_frame(input bit ovr);
    repeat ($urandom_range(0, 2)) begin
      sample_valid = 1'($urandom);
      tick();
    end
    trigger = 1'b1;
    sample_valid = 1'($urandom);
    tick();
    trigger = 1'b0;
    sample_valid = 1'b0;
    for (int k = 0; k < FL; k++) begin
      repeat ($urandom_range(0, 2)) tick();
      sample_valid = 1'b1;
      trigger = ovr && (k == FL / 2 || k == FL - 1);
      tick();
      sample_valid = 1'b0;
      trigger = 1'b0;
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 10 && done_cnt == 0; i++) tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    n_frames = 16'd0; start = 1'b0; abort = 1'b0; trigger = 1'b0; sample_valid = 1'b0;
    repeat (3) tick();
    tests++;
    if ({acc_we, acc_first, acc_addr, frame_idx, busy, done, overrun, timeout} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got we=%b first=%b addr=%0d fidx=%0d busy=%b done=%b ovr=%b tmo=%b, expected all 0",
               acc_we, acc_first, acc_addr, frame_idx, busy, done, overrun, timeout);
    end
    reset_n = 1'b1;
    repeat (2) tick();
    tests++;
    if ({acc_we, busy, done} !== 3'b000) begin
      fails++;
      $display("FAIL reset_release_idle: got we=%b busy=%b done=%b, expected 0", acc_we, busy, done);
    end
  endtask

  task automatic test_multi_frame(input int n, input string tag);
    int nlat;
    nlat = (n == 0) ? 1 : n;
    clear_obs();
    do_start(n);
    tests++;
    if (busy !== 1'b1) begin
      fails++;
      $display("FAIL %s_busy_after_start: got %b, expected 1", tag, busy);
    end
    for (int f = 0; f < nlat; f++) begin
      tests++;
      if (frame_idx !== 16'(f)) begin
        fails++;
        $display("FAIL %s_frame_idx: got %0d, expected %0d", tag, frame_idx, f);
      end
      send_frame(1'b0);
    end
    wait_done();
    tests++;
    if (obs_addr.size() != nlat * FL) begin
      fails++;
      $display("FAIL %s_write_count: got %0d, expected %0d", tag, obs_addr.size(), nlat * FL);
    end
    tests++;
    if (write_errors() != 0) begin
      fails++;
      $display("FAIL %s_write_seq: got %0d bad writes, expected 0", tag, write_errors());
    end
    tests++;
    if (done_cnt != 1 || done_cyc != last_we_cyc + 1 || done_nobusy != 0) begin
      fails++;
      $display("FAIL %s_done: got count=%0d at cyc %0d (last we %0d, nobusy %0d), expected 1 at last_we+1 with busy",
               tag, done_cnt, done_cyc, last_we_cyc, done_nobusy);
    end
    tests++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle_after: got busy=%b overrun=%b, expected 0 0", tag, busy, overrun);
    end
  endtask

  task automatic test_overrun();
    clear_obs();
    do_start(2);
    send_frame(1'b0);
    send_frame(1'b1);
    wait_done();
    tests++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL overrun_set: got %b, expected 1", overrun);
    end
    tests++;
    if (obs_addr.size() != 2 * FL || write_errors() != 0 || done_cnt != 1) begin
      fails++;
      $display("FAIL overrun_sequence: got %0d writes, %0d bad, %0d done, expected %0d, 0, 1",
               obs_addr.size(), write_errors(), done_cnt, 2 * FL);
    end
    clear_obs();
    do_start(1);
    tests++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL overrun_cleared: got %b, expected 0", overrun);
    end
    send_frame(1'b0);
    wait_done();
  endtask

  task automatic test_abort();
    int part;
    part = $urandom_range(1, FL - 2);
    clear_obs();
    do_start(3);
    send_frame(1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    for (int k = 0; k < part; k++) begin
      sample_valid = 1'b1;
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sample_valid = 1'b0;
    tests++;
    if (busy !== 1'b0 || acc_we !== 1'b0) begin
      fails++;
      $display("FAIL abort_stop: got busy=%b acc_we=%b, expected 0 0", busy, acc_we);
    end
    for (int i = 0; i < 20; i++) begin
      trigger = 1'($urandom);
      sample_valid = 1'($urandom);
      tick();
    end
    trigger = 1'b0;
    sample_valid = 1'b0;
    tests++;
    if (obs_addr.size() != FL + part || done_cnt != 0 || write_errors() != 0) begin
      fails++;
      $display("FAIL abort_writes: got %0d writes (%0d bad), %0d done, expected %0d, 0 bad, 0 done",
               obs_addr.size(), write_errors(), done_cnt, FL + part);
    end
    test_multi_frame(1, "after_abort");
  endtask

  task automatic test_start_busy();
    clear_obs();
    do_start(2);
    n_frames = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_frame(1'b0);
    n_frames = 16'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    send_frame(1'b0);
    wait_done();
    tests++;
    if (obs_addr.size() != 2 * FL || done_cnt != 1 || write_errors() != 0) begin
      fails++;
      $display("FAIL start_busy: got %0d writes (%0d bad), %0d done, expected %0d, 0 bad, 1 done",
               obs_addr.size(), write_errors(), done_cnt, 2 * FL);
    end
  endtask

  task automatic test_timeout();
    clear_obs();
    do_start(1);
    repeat (TMO + 5) begin
      sample_valid = 1'($urandom);
      tick();
    end
    sample_valid = 1'b0;
`ifdef COH_AVG_TIMEOUT_EN
    tests++;
    if (timeout !== 1'b1 || busy !== 1'b0 || done_cnt != 0) begin
      fails++;
      $display("FAIL timeout_fire: got timeout=%b busy=%b done=%0d, expected 1 0 0", timeout, busy, done_cnt);
    end
`else
    tests++;
    if (timeout !== 1'b0 || busy !== 1'b1 || obs_addr.size() != 0) begin
      fails++;
      $display("FAIL timeout_disabled: got timeout=%b busy=%b writes=%0d, expected 0 1 0",
               timeout, busy, obs_addr.size());
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
`endif
  endtask

  task automatic test_reset_mid();
    clear_obs();
    do_start(2);
    send_frame(1'b0);
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
    sample_valid = 1'b1;
    repeat (3) tick();
    tests++;
    if (acc_we !== 1'b1 || frame_idx !== 16'd1) begin
      fails++;
      $display("FAIL reset_mid_pre: got acc_we=%b fidx=%0d, expected 1 1", acc_we, frame_idx);
    end
    reset_n = 1'b0;
    #1;
    tests++;
    if ({acc_we, acc_first, acc_addr, frame_idx, busy, done, overrun, timeout} !== '0) begin
      fails++;
      $display("FAIL reset_mid_async: got we=%b first=%b addr=%0d fidx=%0d busy=%b done=%b, expected all 0",
               acc_we, acc_first, acc_addr, frame_idx, busy, done);
    end
    sample_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_multi_frame(3, "three_frames");
    test_multi_frame(0, "zero_frames");
    test_overrun();
    test_abort();
    test_start_busy();
    for (int r = 0; r < 3; r++) test_multi_frame(int'($urandom_range(1, 4)), "random_run");
    test_timeout();
    test_reset_mid();
    test_multi_frame(2, "after_reset");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
